// File: rtl/asyn_fifo_pkg.sv
// Shared pointer widths and Gray/binary conversion helpers for the async FIFO.
package asyn_fifo_pkg;
    localparam int PTR_WIDTH = 4;
    localparam int DEPTH     = 2 ** PTR_WIDTH;

    // One extra MSB distinguishes full from empty when the addresses match.
    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for a synchronized FIFO pointer.
module gray2bin_conv
    import asyn_fifo_pkg::*;
(
    input  logic [PTR_WIDTH:0] gray_i,
    output logic [PTR_WIDTH:0] bin_o
);
    assign bin_o = gray2bin(gray_i);
endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/overflow controller of the async FIFO.
// Define ALMOST_FULL_EN to build the registered almost-full flag.
module wptr_full_ctrl
    import asyn_fifo_pkg::*;
#(
    parameter int AF_MARGIN = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 w_en_i,
    input  logic [PTR_WIDTH:0]   rptr_gray_sync_i,
    output logic                 wr_mem_en_o,
    output logic [PTR_WIDTH-1:0] waddr_o,
    output logic [PTR_WIDTH:0]   wptr_gray_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 overflow_o
);
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("AF_MARGIN out of range 1..DEPTH-1");
    end

    ptr_t wbin;
    ptr_t wbin_next;
    ptr_t wgray_next;
    ptr_t rptr_full_cmp;
    logic accept;
    logic full_next;

    // Decision uses the registered flag, so a slot freed this cycle is usable next cycle.
    assign accept      = w_en_i & ~full_o;
    assign wr_mem_en_o = accept;
    assign waddr_o     = wbin[PTR_WIDTH-1:0];

    assign wbin_next  = wbin + ptr_t'(accept);
    assign wgray_next = bin2gray(wbin_next);

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign rptr_full_cmp = {~rptr_gray_sync_i[PTR_WIDTH:PTR_WIDTH-1],
                            rptr_gray_sync_i[PTR_WIDTH-2:0]};
    assign full_next     = (wgray_next == rptr_full_cmp);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wbin        <= '0;
            wptr_gray_o <= '0;
            full_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray_o <= wgray_next;
            full_o      <= full_next;
            if (w_en_i && full_o)
                overflow_o <= 1'b1;
        end
    end

`ifdef ALMOST_FULL_EN
    ptr_t rbin;
    ptr_t level_next;
    logic almost_full_next;

    gray2bin_conv u_rptr_g2b (
        .gray_i (rptr_gray_sync_i),
        .bin_o  (rbin)
    );

    assign level_next       = wbin_next - rbin;
    assign almost_full_next = (level_next >= ptr_t'(DEPTH - AF_MARGIN));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            almost_full_o <= 1'b0;
        else
            almost_full_o <= almost_full_next;
    end
`else
    assign almost_full_o = 1'b0;
`endif
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomized scoreboard bench for wptr_full_ctrl against a word-count model.
module tb_wptr_full_ctrl;
    localparam int PW     = 4;
    localparam int DEPTHT = 16;
    localparam int AFM    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [PW:0]   rptr = '0;
    logic          wr_mem_en;
    logic [PW-1:0] waddr;
    logic [PW:0]   wgray;
    logic          full, afull, ovf;

    wptr_full_ctrl #(.AF_MARGIN(AFM)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .w_en_i           (w_en),
        .rptr_gray_sync_i (rptr),
        .wr_mem_en_o      (wr_mem_en),
        .waddr_o          (waddr),
        .wptr_gray_o      (wgray),
        .full_o           (full),
        .almost_full_o    (afull),
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [PW-1:0] addr;
        logic [PW:0]   gray;
        logic          full;
        logic          afull;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Model: total words accepted and total words the reader has released.
    int  wc = 0;
    bit  full_m = 0, af_m = 0, ovf_m = 0;
    bit  cur_w = 0;
    int  cur_rc = 0;

    function automatic logic [PW:0] to_gray(input int n);
        int m;
        m = n % 32;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit w, input int rc);
        int lvl;
        if (w && full_m) ovf_m = 1;
        if (w && !full_m) wc++;
        lvl    = wc - rc;
        full_m = (lvl == DEPTHT);
`ifdef ALMOST_FULL_EN
        af_m   = (lvl >= DEPTHT - AFM);
`else
        af_m   = 0;
`endif
    endtask

    task automatic cycle(input bit w, input int rc);
        exp_t e;
        @(posedge clk);
        model_step(cur_w, cur_rc);
        #2;
        cur_w = w; cur_rc = rc;
        w_en = w; rptr = to_gray(rc);
        e.wr_en = w && !full_m;
        e.addr  = 4'(wc % DEPTHT);
        e.gray  = to_gray(wc);
        e.full  = full_m;
        e.afull = af_m;
        e.ovf   = ovf_m;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        w_en  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_waddr", waddr, 0);
        chk("rst_gray", wgray, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_ovf", ovf, 0);
        q.delete();
        wc = 0; full_m = 0; af_m = 0; ovf_m = 0;
        cur_w = 0; cur_rc = 0;
        w_en = 1'b0; rptr = '0;
        #10;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against queued expectations mid-cycle.
    logic [PW:0] last_gray = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_gray = '0;
            end else if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("wr_mem_en", wr_mem_en, e.wr_en);
                chk("waddr", waddr, e.addr);
                chk("wptr_gray", wgray, e.gray);
                chk("full", full, e.full);
                chk("almost_full", afull, e.afull);
                chk("overflow", ovf, e.ovf);
                chk("gray_1bit", ($countones(wgray ^ last_gray) <= 1) ? 1 : 0, 1);
                last_gray = wgray;
            end
        end
    end

    initial begin
        int rc, lag1, lag2;
        #23 rst_n = 1'b1;
        // Fill from empty, then keep writing into a full FIFO.
        for (int i = 0; i < 20; i++) cycle(1'b1, 0);
        // Reader frees one slot while full.
        cycle(1'b0, 1);
        cycle(1'b1, 1);
        cycle(1'b1, 1);
        cycle(1'b0, 1);
        do_reset();
        // Streaming with reader two cycles behind: wraps, never full.
        lag1 = 0; lag2 = 0;
        for (int i = 0; i < 45; i++) begin
            rc = lag2; lag2 = lag1; lag1 = wc;
            cycle(1'b1, rc);
        end
        do_reset();
        // Random producer and reader.
        rc = 0;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 4) == 0 && rc < wc) rc++;
            cycle(($urandom % 10) < 7, rc);
        end
        cycle(1'b0, rc);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
